// File: rtl/step_sequencer.sv
// Step-code sequencer for the datapath control decoder: walks c from 0 to LAST_STEP,
// holding each step DWELL cycles (stretched by stall), with abort, busy and pulse outputs.
module step_sequencer #(
   parameter logic [2:0] LAST_STEP = 3'd7,
   parameter int         DWELL     = 1,
   parameter int         CNT_W     = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stall,
   input  logic       abort,
   output logic [2:0] c,
   output logic       DONE,
   output logic       busy,
   output logic       step_strobe,
   output logic       done_pulse
);

   localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt, cnt_nx;
   logic [2:0]       c_nx;
   logic             strobe_nx, pulse_nx;

   always_comb begin
      state_nx  = state;
      c_nx      = c;
      cnt_nx    = cnt;
      strobe_nx = 1'b0;
      pulse_nx  = 1'b0;
      case (state)
         IDLE: begin
            c_nx   = 3'd0;
            cnt_nx = '0;
            if (start && !abort) begin
               state_nx  = RUN;
               strobe_nx = 1'b1;
            end
         end
         RUN: begin
            // abort has priority over stall; a stalled cycle changes nothing
            if (abort) begin
               state_nx = IDLE;
               c_nx     = 3'd0;
               cnt_nx   = '0;
            end else if (!stall) begin
               if (cnt != DWELL_LAST) begin
                  cnt_nx = cnt + 1'b1;
               end else if (c != LAST_STEP) begin
                  c_nx      = c + 3'd1;
                  cnt_nx    = '0;
                  strobe_nx = 1'b1;
               end else begin
                  state_nx = FIN;
                  cnt_nx   = '0;
                  pulse_nx = 1'b1;
               end
            end
         end
         FIN: begin
            state_nx = IDLE;
            c_nx     = 3'd0;
         end
         default: begin
            state_nx = IDLE;
            c_nx     = 3'd0;
            cnt_nx   = '0;
         end
      endcase
   end

   // DONE and busy are registered from the next state so they move on the same edge as c
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= IDLE;
         c           <= 3'd0;
         cnt         <= '0;
         DONE        <= 1'b1;
         busy        <= 1'b0;
         step_strobe <= 1'b0;
         done_pulse  <= 1'b0;
      end else begin
         state       <= state_nx;
         c           <= c_nx;
         cnt         <= cnt_nx;
         DONE        <= (state_nx != RUN);
         busy        <= (state_nx == RUN);
         step_strobe <= strobe_nx;
         done_pulse  <= pulse_nx;
      end
   end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: default and DWELL=3/LAST_STEP=4 instances driven together,
// checked by a vector table, directed sequences and a progress-count reference model.
module tb_step_sequencer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n, start, stall, abort;
   logic [2:0] c_a, c_b;
   logic       done_a, busy_a, strobe_a, pulse_a;
   logic       done_b, busy_b, strobe_b, pulse_b;

   step_sequencer #(.LAST_STEP(3'd7), .DWELL(1), .CNT_W(4)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
      .c(c_a), .DONE(done_a), .busy(busy_a), .step_strobe(strobe_a), .done_pulse(pulse_a));

   step_sequencer #(.LAST_STEP(3'd4), .DWELL(3), .CNT_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .abort(abort),
      .c(c_b), .DONE(done_b), .busy(busy_b), .step_strobe(strobe_b), .done_pulse(pulse_b));

   int total = 0;
   int bad   = 0;

   // Reference model: a sequence is just a count of unstalled cycles spent in RUN.
   typedef enum {M_IDLE, M_RUN, M_FIN} mode_t;
   typedef struct {
      mode_t mode;
      int    prog;
      bit    fresh;
   } mdl_t;

   mdl_t ma, mb;

   function automatic mdl_t mstep(mdl_t m, bit rn, bit st, bit sl, bit ab, int last, int dw);
      mdl_t n;
      n = m;
      if (!rn) begin
         n.mode = M_IDLE; n.prog = 0; n.fresh = 1'b0;
      end else begin
         case (m.mode)
            M_IDLE: if (st && !ab) begin
               n.mode = M_RUN; n.prog = 0; n.fresh = 1'b1;
            end
            M_RUN: begin
               if (ab) begin
                  n.mode = M_IDLE; n.prog = 0; n.fresh = 1'b0;
               end else if (sl) begin
                  n.fresh = 1'b0;
               end else begin
                  n.prog  = m.prog + 1;
                  n.fresh = 1'b1;
                  if (n.prog == (last + 1) * dw) n.mode = M_FIN;
               end
            end
            default: begin
               n.mode = M_IDLE; n.prog = 0; n.fresh = 1'b0;
            end
         endcase
      end
      return n;
   endfunction

   // {c, DONE, busy, step_strobe, done_pulse}
   function automatic logic [6:0] mexp(mdl_t m, int last, int dw);
      logic [2:0] ce;
      if (m.mode == M_RUN)      ce = 3'(m.prog / dw);
      else if (m.mode == M_FIN) ce = 3'(last);
      else                      ce = 3'd0;
      return {ce, m.mode != M_RUN, m.mode == M_RUN,
              (m.mode == M_RUN) && m.fresh && (m.prog % dw == 0), m.mode == M_FIN};
   endfunction

   task automatic check(string nm, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   function automatic logic [6:0] out_a();
      return {c_a, done_a, busy_a, strobe_a, pulse_a};
   endfunction

   function automatic logic [6:0] out_b();
      return {c_b, done_b, busy_b, strobe_b, pulse_b};
   endfunction

   task automatic cyc();
      @(posedge clk);
      ma = mstep(ma, rst_n, start, stall, abort, 7, 1);
      mb = mstep(mb, rst_n, start, stall, abort, 4, 3);
      #1;
      check("model_a", int'(out_a()), int'(mexp(ma, 7, 1)));
      check("model_b", int'(out_b()), int'(mexp(mb, 4, 3)));
   endtask

   typedef struct {
      bit       rn, st, sl, ab;
      logic [6:0] exp;
   } vec_t;

   vec_t vt[$];

   task automatic add(bit rn, bit st, bit sl, bit ab,
                      int ce, bit d, bit b, bit s, bit p);
      vec_t v;
      v.rn = rn; v.st = st; v.sl = sl; v.ab = ab;
      v.exp = {3'(ce), d, b, s, p};
      vt.push_back(v);
   endtask

   task automatic run_start();
      add(1, 1, 0, 0, 0, 0, 1, 1, 0);
   endtask

   initial begin
      int run_len, strobes, guard;

      rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
      ma = '{M_IDLE, 0, 1'b0};
      mb = '{M_IDLE, 0, 1'b0};

      // reset dominates start
      add(0, 1, 0, 0, 0, 1, 0, 0, 0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // full unstalled run
      run_start();
      for (int k = 1; k <= 7; k++) add(1, 0, 0, 0, k, 0, 1, 1, 0);
      add(1, 0, 0, 0, 7, 1, 0, 0, 1);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // start together with abort stays idle
      add(1, 1, 0, 1, 0, 1, 0, 0, 0);
      // abort at c=5
      run_start();
      for (int k = 1; k <= 5; k++) add(1, 0, 0, 0, k, 0, 1, 1, 0);
      add(1, 0, 0, 1, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // abort beats stall
      run_start();
      add(1, 0, 1, 1, 0, 1, 0, 0, 0);
      // stall ignored in IDLE, honoured in RUN
      add(1, 1, 1, 0, 0, 0, 1, 1, 0);
      add(1, 0, 1, 0, 0, 0, 1, 0, 0);
      add(1, 0, 0, 0, 1, 0, 1, 1, 0);
      add(1, 0, 0, 1, 0, 1, 0, 0, 0);
      // start re-asserted at c=2 and in FIN
      run_start();
      add(1, 0, 0, 0, 1, 0, 1, 1, 0);
      add(1, 0, 0, 0, 2, 0, 1, 1, 0);
      add(1, 1, 0, 0, 3, 0, 1, 1, 0);
      for (int k = 4; k <= 7; k++) add(1, 0, 0, 0, k, 0, 1, 1, 0);
      add(1, 1, 0, 0, 7, 1, 0, 0, 1);
      add(1, 1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);
      // reset at c=6
      run_start();
      for (int k = 1; k <= 6; k++) add(1, 0, 0, 0, k, 0, 1, 1, 0);
      add(0, 1, 0, 0, 0, 1, 0, 0, 0);
      add(1, 0, 0, 0, 0, 1, 0, 0, 0);

      foreach (vt[i]) begin
         rst_n = vt[i].rn; start = vt[i].st; stall = vt[i].sl; abort = vt[i].ab;
         cyc();
         check($sformatf("vec%0d", i), int'(out_a()), int'(vt[i].exp));
      end

      // stall two cycles at c=3 on the default instance
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; abort = 1'b0;
      cyc();
      rst_n = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      run_len = 1;
      repeat (3) begin cyc(); run_len++; end
      check("stall_c3_entry", int'(c_a), 3);
      stall = 1'b1;
      repeat (2) begin
         cyc(); run_len++;
         check("stall_c_hold", int'(c_a), 3);
         check("stall_no_strobe", int'(strobe_a), 0);
      end
      stall = 1'b0;
      guard = 0;
      cyc();
      while (!done_a && guard < 40) begin
         run_len++; guard++;
         cyc();
      end
      check("stall_run_len", run_len, 10);
      check("stall_fin_pulse", int'(pulse_a), 1);

      // DWELL=3, LAST_STEP=4 instance
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      run_len = 0; strobes = 0; guard = 0;
      while (!done_b && guard < 60) begin
         if (strobe_b) begin
            check("dwell_strobe_phase", run_len % 3, 0);
            check("dwell_strobe_c", int'(c_b), run_len / 3);
            strobes++;
         end
         run_len++; guard++;
         cyc();
      end
      check("dwell_run_len", run_len, 15);
      check("dwell_strobes", strobes, 5);
      check("dwell_fin", int'(out_b()), int'({3'd4, 1'b1, 1'b0, 1'b0, 1'b1}));
      cyc();
      check("dwell_idle", int'(out_b()), int'({3'd0, 1'b1, 1'b0, 1'b0, 1'b0}));

      // random traffic against the model
      for (int n = 0; n < 4000; n++) begin
         rst_n = ($urandom_range(0, 63) != 0);
         start = ($urandom_range(0, 3) == 0);
         stall = ($urandom_range(0, 3) == 0);
         abort = ($urandom_range(0, 15) == 0);
         cyc();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
